// File: rtl/demux8_reg_if.sv
// Producer/consumer bundle for demux8_reg: one input stream, eight output streams.
// master drives the producer/consumer side, slave is the demultiplexer itself.
interface demux8_reg_if #(
  parameter int unsigned DataWidth = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DataWidth-1:0]   din;
  logic [2:0]             sel;
  logic [7:0]             out_valid;
  logic [7:0]             out_ready;
  logic [8*DataWidth-1:0] dout;

  modport master (
    output in_valid, din, sel, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, sel, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/demux8_reg.sv
// Registered 1-to-8 demultiplexer with a one-entry holding buffer per destination.
// Define DEMUX8_STALL_CNT_EN to build the saturating input-stall counter on stall_cnt.
module demux8_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  demux8_reg_if.slave       bus,
  output logic [15:0]       stall_cnt
);

  logic [7:0]                valid_q, valid_d;
  logic [7:0][DataWidth-1:0] data_q, data_d;
  logic                      accept;

  // A full buffer may be refilled in the same cycle its consumer drains it.
  assign bus.in_ready  = !flush && (!valid_q[bus.sel] || bus.out_ready[bus.sel]);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.dout      = data_q;

  always_comb begin
    valid_d = valid_q & ~bus.out_ready;
    data_d  = data_q;
    if (accept) begin
      valid_d[bus.sel] = 1'b1;
      data_d[bus.sel]  = bus.din;
    end
    // Flush drops every word but leaves the data registers untouched.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef DEMUX8_STALL_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.in_valid && !bus.in_ready && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_demux8_reg.sv
// Scoreboard bench for demux8_reg: accepted words queue per destination, and a
// consumer monitor pops and compares on every output transfer.
module tb_demux8_reg;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[8][$];

  demux8_reg_if #(.DataWidth(32)) bus ();

  demux8_reg #(.DataWidth(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slice(input int i);
    return bus.dout[i*32 +: 32];
  endfunction

  // Issue one word and wait (bounded) for acceptance; returns the cycles stalled.
  task automatic send(input logic [2:0] s, input logic [31:0] d, output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.din      = d;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      exp_q[s].push_back(d);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] m);
    bus.out_ready = m;
    step();
    bus.out_ready = 8'h00;
  endtask

  // Consumer monitor: a transfer happens on the next edge whenever valid && ready.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_out%0d", i), slice(i), 32'hxxxx_xxxx);
          end else begin
            chk($sformatf("out%0d_data", i), slice(i), exp_q[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int left;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd3;
    bus.din       = 32'hA5A5A5A5;
    bus.out_ready = 8'h00;

    // Reset holds everything clear even with a word offered.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {24'd0, bus.out_valid}, 32'h0);
    chk("rst_dout", {31'd0, (bus.dout == '0)}, 32'd1);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'h0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    exp_q[3].push_back(32'hA5A5A5A5);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("first_out_valid", {24'd0, bus.out_valid}, 32'h08);
    chk("first_dout3", slice(3), 32'hA5A5A5A5);
    step();
    drain(8'h08);

    // Fill all eight buffers, then a ninth word to buffer 5 must stall.
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 32'h100 + i, w);
    end
    @(negedge clk);
    chk("fill_out_valid", {24'd0, bus.out_valid}, 32'hFF);
    step();
    bus.in_valid = 1'b1;
    bus.sel      = 3'd5;
    bus.din      = 32'h999;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
`ifdef DEMUX8_STALL_CNT_EN
    chk("stall_cnt_4", {16'd0, stall_cnt}, 32'd4);
`else
    chk("stall_cnt_off", {16'd0, stall_cnt}, 32'd0);
`endif
    step();
    drain(8'hFF);
    @(negedge clk);
    chk("drained_out_valid", {24'd0, bus.out_valid}, 32'h0);
    step();

    // Stream five words to destination 2 with its consumer always ready.
    bus.out_ready = 8'h04;
    for (int k = 1; k <= 5; k++) begin
      bus.in_valid = 1'b1;
      bus.sel      = 3'd2;
      bus.din      = 32'(k);
      @(negedge clk);
      chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (k > 1) chk("stream_valid2", {31'd0, bus.out_valid[2]}, 32'd1);
      exp_q[2].push_back(32'(k));
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_valid2_last", {31'd0, bus.out_valid[2]}, 32'd1);
    step();
    bus.out_ready = 8'h00;
    @(negedge clk);
    chk("stream_done", {24'd0, bus.out_valid}, 32'h0);
    step();

    // Drain 6 and refill it in one cycle while buffer 1 drains alone.
    send(3'd6, 32'h66, w);
    send(3'd1, 32'h11, w);
    bus.out_ready = 8'h42;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd6;
    bus.din       = 32'h77;
    @(negedge clk);
    chk("simul_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q[6].push_back(32'h77);
    step();
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("simul_out_valid", {24'd0, bus.out_valid}, 32'h40);
    chk("simul_dout6", slice(6), 32'h77);
    step();
    drain(8'h40);

    // Flush with a word offered: nothing stored, all valids drop.
    send(3'd1, 32'h21, w);
    send(3'd3, 32'h23, w);
    send(3'd4, 32'h24, w);
    send(3'd6, 32'h26, w);
    @(negedge clk);
    chk("preflush_out_valid", {24'd0, bus.out_valid}, 32'h5A);
    step();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.sel      = 3'd0;
    bus.din      = 32'hDEAD;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {24'd0, bus.out_valid}, 32'h0);
    chk("flush_dout0_kept", slice(0), 32'h100);
    chk("flush_dout1_kept", slice(1), 32'h21);
`ifdef DEMUX8_STALL_CNT_EN
    chk("stall_cnt_flush", {16'd0, stall_cnt}, 32'd5);
`else
    chk("stall_cnt_flush_off", {16'd0, stall_cnt}, 32'd0);
`endif
    step();

    // Long stall on a full buffer 5.
    send(3'd5, 32'h55, w);
    bus.in_valid = 1'b1;
    bus.sel      = 3'd5;
    bus.din      = 32'h56;
`ifdef DEMUX8_STALL_CNT_EN
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
    step();
    @(negedge clk);
    chk("stall_cnt_nowrap", {16'd0, stall_cnt}, 32'hFFFF);
`else
    repeat (20) step();
    @(negedge clk);
    chk("stall_cnt_zero", {16'd0, stall_cnt}, 32'd0);
`endif
    step();
    bus.in_valid = 1'b0;
    drain(8'h20);

    left = 0;
    for (int i = 0; i < 8; i++) left += exp_q[i].size();
    chk("scoreboard_empty", 32'(left), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
